// File: rtl/common.sv
// Shared types and funct3 encodings for the load/store unit.
package common;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SW = 3'b010;

  // True when the size code exists for the access type and the address is naturally aligned.
  function automatic logic access_legal(input logic is_store, input logic [2:0] size,
                                        input logic [1:0] addr_lo);
    logic legal_v;
    legal_v = 1'b0;
    if (is_store) begin
      case (size)
        SB:      legal_v = 1'b1;
        SH:      legal_v = (addr_lo[0] == 1'b0);
        SW:      legal_v = (addr_lo == 2'b00);
        default: legal_v = 1'b0;
      endcase
    end else begin
      case (size)
        LB, LBU: legal_v = 1'b1;
        LH, LHU: legal_v = (addr_lo[0] == 1'b0);
        LW:      legal_v = (addr_lo == 2'b00);
        default: legal_v = 1'b0;
      endcase
    end
    return legal_v;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables/replicated write data and load extract/extend.
module lsu_align
  import common::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [31:0] shifted_s;

  assign shifted_s = rdata >> {addr_lo, 3'b000};

  // Lane enables and write data depend only on the access width bits.
  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0000_0000;
    case (size[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load result extension selected by the full funct3.
  always_comb begin
    ldata = 32'h0000_0000;
    case (size)
      LB:      ldata = {{24{shifted_s[7]}}, shifted_s[7:0]};
      LH:      ldata = {{16{shifted_s[15]}}, shifted_s[15:0]};
      LW:      ldata = shifted_s;
      LBU:     ldata = {24'h00_0000, shifted_s[7:0]};
      LHU:     ldata = {16'h0000, shifted_s[15:0]};
      default: ldata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store engine with a single-outstanding req/gnt/rvalid bus.
// Optional WAIT timeout fault is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_mem2reg,
  input  logic        ctrl_mem_write,
  input  logic [2:0]  ctrl_load_size,
  input  logic [2:0]  ctrl_store_size,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        lsu_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  lsu_state_t  state_r, state_s;
  logic        req_s, legal_s, timeout_s;
  logic [2:0]  req_size_s, align_size_s, size_r;
  logic [1:0]  align_lo_s, addr_lo_r;
  logic        we_r, fault_r;
  logic [3:0]  be_s;
  logic [31:0] wdata_s, ldata_s;
  logic        mem_we_r;
  logic [31:0] mem_addr_r, mem_wdata_r, load_data_r;
  logic [3:0]  mem_be_r;

  assign req_s      = ctrl_mem_write | ctrl_mem2reg;
  assign req_size_s = ctrl_mem_write ? ctrl_store_size : ctrl_load_size;
  assign legal_s    = access_legal(ctrl_mem_write, req_size_s, addr[1:0]);

  // The aligner sees the incoming instruction in IDLE and the captured one afterwards.
  assign align_size_s = (state_r == IDLE) ? req_size_s : size_r;
  assign align_lo_s   = (state_r == IDLE) ? addr[1:0] : addr_lo_r;

  lsu_align u_align (
    .size       (align_size_s),
    .addr_lo    (align_lo_s),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .ldata      (ldata_s)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt_r;

  // WAIT-cycle counter, held at zero outside WAIT so it restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= '0;
    end else if (state_r != WAIT) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 1'b1;
    end
  end

  assign timeout_s = (state_r == WAIT) && (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES != 0);
  assign timeout_s        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; rvalid takes priority over an expiring timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          state_s = legal_s ? REQ : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rvalid || timeout_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the registered state and captured flags.
  always_comb begin
    mem_req    = 1'b0;
    lsu_stall  = 1'b0;
    load_valid = 1'b0;
    lsu_fault  = 1'b0;
    case (state_r)
      IDLE: lsu_stall = req_s;
      REQ: begin
        mem_req   = 1'b1;
        lsu_stall = 1'b1;
      end
      WAIT: lsu_stall = 1'b1;
      DONE: begin
        load_valid = ~we_r & ~fault_r;
        lsu_fault  = fault_r;
      end
      default: lsu_stall = 1'b0;
    endcase
  end

  // Instruction capture, request fields and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r        <= 1'b0;
      size_r      <= 3'b000;
      addr_lo_r   <= 2'b00;
      fault_r     <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
      mem_wdata_r <= 32'h0000_0000;
      load_data_r <= 32'h0000_0000;
    end else if ((state_r == IDLE) && req_s) begin
      we_r      <= ctrl_mem_write;
      size_r    <= req_size_s;
      addr_lo_r <= addr[1:0];
      fault_r   <= ~legal_s;
      if (legal_s) begin
        mem_we_r    <= ctrl_mem_write;
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_be_r    <= be_s;
        mem_wdata_r <= ctrl_mem_write ? wdata_s : 32'h0000_0000;
      end
    end else if ((state_r == WAIT) && mem_rvalid) begin
      fault_r <= mem_err;
      if (!we_r && !mem_err) begin
        load_data_r <= ldata_s;
      end
    end else if (timeout_s) begin
      fault_r <= 1'b1;
    end
  end

  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_be    = mem_be_r;
  assign mem_wdata = mem_wdata_r;
  assign load_data = load_data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases, then random accesses vs. a reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_mem2reg, ctrl_mem_write;
  logic [2:0]  ctrl_load_size, ctrl_store_size;
  logic [31:0] addr, store_data;
  logic        lsu_stall, load_valid, lsu_fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid, mem_err;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_load_data = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ctrl_mem2reg(ctrl_mem2reg), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_load_size(ctrl_load_size), .ctrl_store_size(ctrl_store_size),
    .addr(addr), .store_data(store_data),
    .lsu_stall(lsu_stall), .load_data(load_data), .load_valid(load_valid), .lsu_fault(lsu_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete access; gd = cycles before grant, rd = WAIT cycles before rvalid.
  task automatic run_access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input int gd, input int rd,
                            input logic [31:0] rdata, input bit err);
    int unsigned nbytes, off;
    bit legal;
    logic [31:0] mask, v, be_e, wd_e;
    off    = a % 4;
    nbytes = 1 << (sz % 4);
    legal  = we ? (sz <= 3'd2) : (sz inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    legal  = legal && ((a % nbytes) == 0);
    mask   = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    be_e   = ((32'd1 << nbytes) - 32'd1) << off;
    if (!we)              wd_e = 32'h0;
    else if (nbytes == 1) wd_e = (d & 32'hFF) * 32'h0101_0101;
    else if (nbytes == 2) wd_e = (d & 32'hFFFF) * 32'h0001_0001;
    else                  wd_e = d;
    v = (rdata >> (8 * off)) & mask;
    if (!sz[2] && nbytes < 4 && ((v & ((mask >> 1) + 32'd1)) != 0)) v = v | ~mask;

    @(negedge clk);
    ctrl_mem_write = we; ctrl_mem2reg = !we;
    ctrl_store_size = sz; ctrl_load_size = sz; addr = a; store_data = d;
    #1;
    chk("stall_t0", {31'b0, lsu_stall}, 32'd1);
    chk("req_t0", {31'b0, mem_req}, 32'd0);
    @(posedge clk); #1;
    ctrl_mem_write = 1'b0; ctrl_mem2reg = 1'b0;
    @(negedge clk);
    if (!legal) begin
      chk("fault_pulse", {31'b0, lsu_fault}, 32'd1);
      chk("fault_stall", {31'b0, lsu_stall}, 32'd0);
      chk("fault_noreq", {31'b0, mem_req}, 32'd0);
      chk("fault_novalid", {31'b0, load_valid}, 32'd0);
      @(posedge clk);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req", {31'b0, mem_req}, 32'd1);
      chk("req_stall", {31'b0, lsu_stall}, 32'd1);
      chk("mem_we", {31'b0, mem_we}, {31'b0, we});
      chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      chk("mem_be", {28'b0, mem_be}, be_e);
      chk("mem_wdata", mem_wdata, wd_e);
      if (i == gd) mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i <= rd; i++) begin
      chk("wait_noreq", {31'b0, mem_req}, 32'd0);
      chk("wait_stall", {31'b0, lsu_stall}, 32'd1);
      if (i == rd) begin
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
      end
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
    end
    if (!we && !err) exp_load_data = v;
    chk("done_stall", {31'b0, lsu_stall}, 32'd0);
    chk("load_valid", {31'b0, load_valid}, {31'b0, (!we && !err)});
    chk("lsu_fault", {31'b0, lsu_fault}, {31'b0, err});
    chk("load_data", load_data, exp_load_data);
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ctrl_mem2reg = 1'b0; ctrl_mem_write = 1'b0; ctrl_load_size = 3'b0; ctrl_store_size = 3'b0;
    addr = 32'h0; store_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_valid", {31'b0, load_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed cases from the intended behaviour.
    run_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 0, 32'h8000_0000, 1'b0);
    chk("lb_value", load_data, 32'hFFFF_FF80);
    run_access(1'b0, 3'b101, 32'h0000_2002, 32'h0, 0, 0, 32'hBEEF_1234, 1'b0);
    chk("lhu_value", load_data, 32'h0000_BEEF);
    run_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 32'hBEEF_1234, 1'b0);
    chk("lh_value", load_data, 32'hFFFF_BEEF);
    run_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'b010, 32'h0000_1001, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(1'b1, 3'b011, 32'h0000_1000, 32'h1234_5678, 0, 0, 32'h0, 1'b0);
    run_access(1'b0, 3'b110, 32'h0000_1000, 32'h0, 0, 0, 32'h0, 1'b0);
    run_access(1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 3, 2, 32'h0, 1'b0);
    run_access(1'b0, 3'b010, 32'h0000_3004, 32'h0, 1, 0, 32'h1111_2222, 1'b1);

    // Reset while waiting for a response abandons the access.
    @(negedge clk);
    ctrl_mem2reg = 1'b1; ctrl_load_size = 3'b010; addr = 32'h0000_4000;
    @(posedge clk); #1; ctrl_mem2reg = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    @(negedge clk);
    chk("pre_rst_wait_stall", {31'b0, lsu_stall}, 32'd1);
    rst = 1'b1; #1;
    chk("arst_req", {31'b0, mem_req}, 32'd0);
    chk("arst_stall", {31'b0, lsu_stall}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_load_data", load_data, 32'd0);
    exp_load_data = 32'h0;
    @(negedge clk); rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1; mem_rvalid = 1'b0;
    @(negedge clk);
    chk("late_rvalid_valid", {31'b0, load_valid}, 32'd0);
    chk("late_rvalid_fault", {31'b0, lsu_fault}, 32'd0);
    chk("late_rvalid_stall", {31'b0, lsu_stall}, 32'd0);
    chk("late_rvalid_data", load_data, 32'd0);

`ifdef LSU_TIMEOUT_EN
    // No response: four WAIT cycles then a fault.
    @(negedge clk);
    ctrl_mem2reg = 1'b1; ctrl_load_size = 3'b010; addr = 32'h0000_5000;
    @(posedge clk); #1; ctrl_mem2reg = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); #1; mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_wait_stall", {31'b0, lsu_stall}, 32'd1);
      chk("to_wait_fault", {31'b0, lsu_fault}, 32'd0);
    end
    @(negedge clk);
    chk("to_fault", {31'b0, lsu_fault}, 32'd1);
    chk("to_stall", {31'b0, lsu_stall}, 32'd0);
    @(posedge clk);
`endif

    // Randomized accesses, including illegal sizes and misalignment.
    for (int n = 0; n < 150; n++) begin
      bit we_v;
      logic [2:0] sz_v;
      we_v = $urandom_range(0, 1);
      sz_v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) sz_v = we_v ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      if (sz_v == 3'b110) sz_v = 3'b101;
      run_access(we_v, sz_v, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
